// File: rtl/gated_sample_pkg.sv
// Shared defaults and index types for the gated sample FIFO.
// Imported by the FIFO top and its storage array.
package gated_sample_pkg;

    localparam int WIDTH_DEF = 3;
    localparam int DEPTH_DEF = 4;
    localparam int PTR_W_DEF = $clog2(DEPTH_DEF);

    typedef logic [PTR_W_DEF-1:0] ptr_t;
    typedef logic [PTR_W_DEF:0]   cnt_t;

endpackage

// File: rtl/gated_sample_mem.sv
// DEPTH x WIDTH register array for the gated sample FIFO.
// Synchronous write port, asynchronous read port, no reset.
module gated_sample_mem
    import gated_sample_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Store the incoming word at the write address.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/gated_sample_fifo.sv
// First-word-fall-through FIFO fed by the enable-gated capture stage.
// One sample per clock while in_en is high; drops are flagged stickily.
module gated_sample_fifo
    import gated_sample_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_en,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             push, pop;
    logic [WIDTH-1:0] rdata;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign out_valid = ~empty;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign out_data  = out_valid ? rdata : '0;

    // A pop frees the head slot, so a push at full is still accepted.
    assign pop  = out_valid & out_ready;
    assign push = in_en & (~full | pop);

    gated_sample_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(PTR_W)
    ) u_mem (
        .clk    (clk),
        .we_i   (push & ~rst),
        .waddr_i(wr_ptr_q),
        .wdata_i(in_data),
        .raddr_i(rd_ptr_q),
        .rdata_o(rdata)
    );

    // Next pointers, occupancy and drop flag from the qualified events.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (in_en & ~push) begin
            overflow_d = 1'b1;
        end
    end

    // Control state register; reset discards all entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: doc/gated_sample_fifo.md
Name: gated_sample_fifo

Overview:
- Downstream consumer of the enable-gated capture stage.
- Takes the 1-bit enable net `y` and the 3-bit data word `z`, and pushes `z` into a small first-word-fall-through FIFO on every clock where the enable is high.
- Drains the FIFO through a valid/ready handshake.
- Turns the level-sensitive hold behaviour upstream into a clocked, lossless-or-flagged sample stream for the next stage.

Parameters:
- WIDTH, 3, data word width; matches z.
- DEPTH, 4, number of entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, derived; width of the occupancy count.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_en  input  1  push request; driven by y.
- in_data  input  WIDTH  word to store; driven by z.
- out_valid  output  1  head entry present.
- out_ready  input  1  consumer accepts head this cycle.
- out_data  output  WIDTH  head entry; 0 when empty.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky: a push was dropped.

Behaviour:
Reset (rst=1 at clk edge):
- rd_ptr = wr_ptr = 0; count = 0; overflow = 0.
- Resulting outputs: out_valid=0, out_data=0, empty=1, full=0.
- Storage contents are don't-care and need not be cleared.
- Reset mid-stream discards all entries; any push/pop in the same cycle is ignored.

Qualified events (evaluated from registered state at the edge):
- pop = out_valid & out_ready.
- push = in_en & (~full | pop).

Next-state rules:
- push: mem[wr_ptr] <= in_data; wr_ptr <= wr_ptr+1, mod DEPTH.
- pop: rd_ptr <= rd_ptr+1, mod DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Pointers are log2(DEPTH) bits and wrap naturally; there is no separate wrap bit, because count disambiguates full from empty.

Outputs (combinational from registers):
- out_valid = (count != 0).
- out_data = out_valid ? mem[rd_ptr] : 0.
- full, empty decoded from count.

Latency and flow:
- A pushed word is visible at out_data on the cycle after the push edge.
- No same-cycle bypass when empty: a push into an empty FIFO does not assert out_valid that cycle.
- Full with pop and push together: both occur; count stays DEPTH; the new word lands in the freed slot.
- Full with in_en and no pop: word dropped; pointers and count unchanged; overflow <= 1 and stays 1 until rst.
- Empty with out_ready: no effect; out_ready may be high at any time.
- in_en is sampled every cycle. A y held high for N cycles pushes N copies of the current z; this is intended, one sample per clock.

Invariants (verification asserts):
- count <= DEPTH.
- count == (wr_ptr - rd_ptr) mod DEPTH, except when count == DEPTH.
- full & empty never both 1.
- overflow never falls without rst.

Decomposition:
- Shared package gated_sample_pkg holds:
  - localparam defaults WIDTH_DEF=3, DEPTH_DEF=4;
  - a ptr_t typedef of log2(DEPTH_DEF) bits;
  - a cnt_t typedef of log2(DEPTH_DEF)+1 bits.
- One sub-module is natural: gated_sample_mem, a DEPTH x WIDTH register array with synchronous write port (we, waddr, wdata) and asynchronous read port (raddr, rdata), no reset.
- Pointer/count control and flags stay in the top.

Test Plan:
- Reset: rst=1 for 2 cycles with in_en=1, in_data=3'b101 -> count=0, empty=1, out_valid=0, out_data=0, overflow=0 after release.
- Order and fall-through: out_ready=0; push 3'd1,3'd2,3'd3 on consecutive cycles -> count=3, out_data=1 one cycle after the first push. Then out_ready=1 for 3 cycles -> out_data sequence 1,2,3, then empty=1.
- Full and overflow: out_ready=0; push 5,6,7,4 -> full=1. Push 3'd2 -> count stays 4, overflow=1, contents still 5,6,7,4. Drain -> 5,6,7,4; overflow remains 1.
- Simultaneous at full: fill with 1,2,3,4; then in_en=1, in_data=0, out_ready=1 for one cycle -> count=4, head becomes 2. Drain order 2,3,4,0.
- Wrap-around: 10 cycles alternating push-only and pop-only with data 0..4 -> pointers wrap past 3; output stream 0,1,2,3,4 with no loss; count ends 0.
- Reset mid-stream: 3 entries queued, rst=1 with in_en=1 and out_ready=1 -> next cycle count=0, out_valid=0. A subsequent push of 3'd6 is read out as 6.
